// File: rtl/md_unit_pkg.sv
// Shared MDOp encodings and op-class helpers for the E-stage multiply/divide unit.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MFHI  = 4'd4,
    MD_MFLO  = 4'd5,
    MD_MTHI  = 4'd6,
    MD_MTLO  = 4'd7,
    MD_MADD  = 4'd8,
    MD_MADDU = 4'd9,
    MD_MSUB  = 4'd10,
    MD_MSUBU = 4'd11,
    MD_NONE  = 4'b1111
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_start_op(input md_op_e op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_start_op = 1'b1;
      default:                              is_start_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage <-> multiply/divide unit request/response bundle.
interface md_unit_if
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) ();
  logic             start;
  md_op_e           md_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] md_rd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, rs_val, rt_val, cancel,
                  input  busy, md_rd, hi, lo);
  modport slave  (input  start, md_op, rs_val, rt_val, cancel,
                  output busy, md_rd, hi, lo);
endinterface

// File: rtl/md_unit_calc.sv
// Combinational HI/LO result for mult/div/accumulate ops, including
// divide-by-zero and signed-overflow rules.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [W2-1:0]    sx_a, sx_b, prod_s;
  logic        [W2-1:0]    prod_u, acc, prod;
  logic                    div0, ovf, sgn;
  logic        [WIDTH-1:0] safe_b, q_u, r_u;
  logic signed [WIDTH-1:0] sa, sb, q_s, r_s;

  assign sx_a   = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
  assign sx_b   = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
  assign prod_s = sx_a * sx_b;
  assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
  assign acc    = {hi, lo};
  assign sgn    = (md_op == MD_MULT) || (md_op == MD_MADD) || (md_op == MD_MSUB);
  assign prod   = sgn ? prod_s : prod_u;

  // Divisor is forced to 1 for the special cases so the dividers never see
  // a trapping operand pair; their outputs are overridden below anyway.
  assign div0   = (rt_val == '0);
  assign ovf    = (md_op == MD_DIV) && (rs_val == SMIN) && (rt_val == '1);
  assign safe_b = (div0 || ovf) ? WIDTH'(1) : rt_val;
  assign sa     = rs_val;
  assign sb     = safe_b;
  assign q_s    = sa / sb;
  assign r_s    = sa % sb;
  assign q_u    = rs_val / safe_b;
  assign r_u    = rs_val % safe_b;

  always_comb begin
    {res_hi, res_lo} = acc;
    case (md_op)
      MD_MULT, MD_MULTU:  {res_hi, res_lo} = prod;
      MD_MADD, MD_MADDU:  {res_hi, res_lo} = acc + prod;
      MD_MSUB, MD_MSUBU:  {res_hi, res_lo} = acc - prod;
      MD_DIV, MD_DIVU: begin
        if (div0) begin
          res_lo = '1;
          res_hi = rs_val;
        end else if (ovf) begin
          res_lo = SMIN;
          res_hi = '0;
        end else if (md_op == MD_DIV) begin
          res_lo = q_s;
          res_hi = r_s;
        end else begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: IDLE/RUN FSM, latency counter, pending
// result and committed HI/LO registers.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);
  localparam int MAXLAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  md_state_e        state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, pend_hi, pend_lo, res_hi, res_lo;
  logic             launch, commit, idle_ok;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .md_op  (md.md_op),
    .rs_val (md.rs_val),
    .rt_val (md.rt_val),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign idle_ok = (state == MD_IDLE) && !md.cancel;
  assign launch  = idle_ok && md.start && is_start_op(md.md_op);
  assign commit  = (state == MD_RUN) && !md.cancel && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MD_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (launch) state_nx = MD_RUN;
      MD_RUN:  if (md.cancel || cnt == '0) state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_comb begin
    md.busy  = (state == MD_RUN);
    md.md_rd = '0;
    if (md.md_op == MD_MFHI)      md.md_rd = hi_q;
    else if (md.md_op == MD_MFLO) md.md_rd = lo_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (launch) begin
      cnt     <= is_div_op(md.md_op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      pend_hi <= res_hi;
      pend_lo <= res_lo;
    end else if (state == MD_RUN && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // mthi/mtlo only land while idle and not flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= pend_hi;
      lo_q <= pend_lo;
    end else if (idle_ok && md.md_op == MD_MTHI) begin
      hi_q <= md.rs_val;
    end else if (idle_ok && md.md_op == MD_MTLO) begin
      lo_q <= md.rs_val;
    end
  end

  assign md.hi = hi_q;
  assign md.lo = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed checks for md_unit: latency, arithmetic, special divides, mt*/mf*,
// accumulate, cancel and mid-op reset.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  md_unit_if #(.WIDTH(32)) md ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    md.start  = 1'b0;
    md.md_op  = MD_NONE;
    md.rs_val = '0;
    md.rt_val = '0;
    md.cancel = 1'b0;
  endtask

  task automatic mt(input md_op_e op, input logic [31:0] v);
    md.md_op  = op;
    md.rs_val = v;
    step();
    idle_in();
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    md.start  = 1'b1;
    md.md_op  = op;
    md.rs_val = a;
    md.rt_val = b;
    step();
    idle_in();
  endtask

  // Counts busy cycles after the start edge, bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (md.busy && n < 64) begin
      n++;
      step();
    end
    chk(tag, 32'(n), 32'(exp_lat));
  endtask

  task automatic op(input string tag, input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                    input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, a, b);
    wait_done({tag, "_lat"}, lat);
    chk({tag, "_hi"}, md.hi, ehi);
    chk({tag, "_lo"}, md.lo, elo);
  endtask

  initial begin
    idle_in();
    #12;
    chk("rst_hi", md.hi, 32'h0);
    chk("rst_lo", md.lo, 32'h0);
    chk("rst_busy", 32'(md.busy), 32'h0);
    reset = 1'b1;
    step();

    op("mult",  MD_MULT,  32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    md.md_op = MD_MFLO; #1;
    chk("mflo", md.md_rd, 32'hFFFF_FFFE);
    md.md_op = MD_MFHI; #1;
    chk("mfhi", md.md_rd, 32'h0000_0001);
    md.md_op = MD_NONE; #1;
    chk("rd_none", md.md_rd, 32'h0);

    op("div",    MD_DIV,  32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op("divu0",  MD_DIVU, 32'h0000_0064, 32'd0,        10, 32'h0000_0064, 32'hFFFF_FFFF);
    op("div0",   MD_DIV,  32'hFFFF_FFFB, 32'd0,        10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    op("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    op("divu",   MD_DIVU, 32'hFFFF_FFFF, 32'd10,       10, 32'h0000_0005, 32'h1999_9999);

    mt(MD_MTHI, 32'd0);
    mt(MD_MTLO, 32'd10);
    chk("mthi", md.hi, 32'd0);
    chk("mtlo", md.lo, 32'd10);
    op("madd", MD_MADD, 32'd3, 32'd4,  5, 32'h0, 32'd22);
    op("msub", MD_MSUB, 32'd2, 32'd20, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEE);

    // Cancel in busy cycle 2 leaves the pre-op HI/LO.
    mt(MD_MTHI, 32'hAA);
    mt(MD_MTLO, 32'h55);
    issue(MD_MULT, 32'd7, 32'd9);
    step();
    md.cancel = 1'b1;
    step();
    md.cancel = 1'b0;
    chk("cancel_busy", 32'(md.busy), 32'h0);
    repeat (6) step();
    chk("cancel_hi", md.hi, 32'hAA);
    chk("cancel_lo", md.lo, 32'h55);

    // Cancel while idle blocks start and mthi.
    md.cancel = 1'b1;
    issue(MD_MULT, 32'd7, 32'd9);
    chk("cancel_idle_start", 32'(md.busy), 32'h0);
    md.cancel = 1'b1;
    mt(MD_MTHI, 32'h1234);
    chk("cancel_idle_mthi", md.hi, 32'hAA);

    // mtlo and a second start during RUN are ignored.
    issue(MD_MULTU, 32'd3, 32'd3);
    md.md_op = MD_MTLO; md.rs_val = 32'h1234;
    step();
    md.start = 1'b1; md.md_op = MD_DIV; md.rs_val = 32'd50; md.rt_val = 32'd7;
    step();
    idle_in();
    wait_done("run_ign_lat", 3);
    chk("run_ign_hi", md.hi, 32'h0);
    chk("run_ign_lo", md.lo, 32'd9);

    op("maddu", MD_MADDU, 32'hFFFF_FFFF, 32'd2, 5, 32'h2, 32'h7);
    op("msubu", MD_MSUBU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0, 32'h9);

    // Reset mid-div discards everything.
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(md.busy), 32'h0);
    chk("rst_mid_hi", md.hi, 32'h0);
    chk("rst_mid_lo", md.lo, 32'h0);
    reset = 1'b1;
    repeat (12) step();
    chk("rst_mid_after_lo", md.lo, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
